// File: rtl/connect_four_controller_if.sv
// Datapath link of the Connect Four controller: feedback in, strobes out.
// The controller takes the master side, the board datapath the slave side.
interface connect_four_controller_if;
  logic       column_full;
  logic       win_found;
  logic       board_full;
  logic [1:0] current_player;
  logic       clear_board;
  logic       validate_enable;
  logic       find_row_enable;
  logic       drop_token;
  logic       switch_player_enable;

  modport master (
    input  column_full,
    input  win_found,
    input  board_full,
    input  current_player,
    output clear_board,
    output validate_enable,
    output find_row_enable,
    output drop_token,
    output switch_player_enable
  );

  modport slave (
    output column_full,
    output win_found,
    output board_full,
    output current_player,
    input  clear_board,
    input  validate_enable,
    input  find_row_enable,
    input  drop_token,
    input  switch_player_enable
  );
endinterface

// File: rtl/connect_four_controller.sv
// Connect Four game FSM: cursor, move sequencing and win/draw detection.
// Define CF_CURSOR_WRAP_EN to make the cursor wrap at both column edges.
module connect_four_controller #(
  parameter int NUM_COLS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_drop,
  input  logic       btn_restart,
  connect_four_controller_if.master dp,
  output logic [2:0] cursor_col,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] MAX_COL = 3'(NUM_COLS - 1);

  typedef enum logic [3:0] {
    S_CLEAR,
    S_WAIT,
    S_VALIDATE,
    S_CHECK,
    S_FIND,
    S_DROP,
    S_SWITCH,
    S_WIN,
    S_DRAW
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] cursor_nx;
  logic [1:0] winner_nx;
  logic [2:0] left_col;
  logic [2:0] right_col;
  logic       restart;

`ifdef CF_CURSOR_WRAP_EN
  assign left_col  = (cursor_col == 3'd0) ? MAX_COL
                                          : cursor_col - 3'd1;
  assign right_col = (cursor_col >= MAX_COL) ? 3'd0
                                             : cursor_col + 3'd1;
`else
  assign left_col  = (cursor_col == 3'd0) ? 3'd0
                                          : cursor_col - 3'd1;
  assign right_col = (cursor_col >= MAX_COL) ? MAX_COL
                                             : cursor_col + 3'd1;
`endif

  assign restart = btn_restart && (state != S_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CLEAR;
      cursor_col <= 3'd0;
      winner     <= 2'b00;
    end else begin
      state      <= state_nx;
      cursor_col <= cursor_nx;
      winner     <= winner_nx;
    end
  end

  always_comb begin
    state_nx                = state;
    cursor_nx               = cursor_col;
    winner_nx               = winner;
    dp.clear_board          = 1'b0;
    dp.validate_enable      = 1'b0;
    dp.find_row_enable      = 1'b0;
    dp.drop_token           = 1'b0;
    dp.switch_player_enable = 1'b0;
    game_over               = 1'b0;
    state_dbg               = 3'd0;
    unique case (state)
      S_CLEAR: begin
        dp.clear_board = 1'b1;
        winner_nx      = 2'b00;
        state_nx       = S_WAIT;
      end
      S_WAIT: begin
        state_dbg = 3'd1;
        if (btn_drop)
          state_nx = S_VALIDATE;
        else if (btn_left && !btn_right)
          cursor_nx = left_col;
        else if (btn_right && !btn_left)
          cursor_nx = right_col;
      end
      S_VALIDATE: begin
        state_dbg          = 3'd2;
        dp.validate_enable = 1'b1;
        state_nx           = S_CHECK;
      end
      S_CHECK: begin
        state_dbg = 3'd3;
        state_nx  = dp.column_full ? S_WAIT : S_FIND;
      end
      S_FIND: begin
        state_dbg          = 3'd4;
        dp.find_row_enable = 1'b1;
        state_nx           = S_DROP;
      end
      S_DROP: begin
        state_dbg     = 3'd5;
        dp.drop_token = 1'b1;
        // a win on the last free cell still counts as a win
        if (dp.win_found) begin
          state_nx  = S_WIN;
          winner_nx = dp.current_player;
        end else if (dp.board_full) begin
          state_nx  = S_DRAW;
          winner_nx = 2'b11;
        end else begin
          state_nx  = S_SWITCH;
        end
      end
      S_SWITCH: begin
        state_dbg               = 3'd6;
        dp.switch_player_enable = 1'b1;
        state_nx                = S_WAIT;
      end
      S_WIN, S_DRAW: begin
        state_dbg = 3'd7;
        game_over = 1'b1;
      end
      default: state_nx = S_CLEAR;
    endcase
    if (restart) begin
      state_nx  = S_CLEAR;
      cursor_nx = 3'd0;
      winner_nx = 2'b00;
    end
    // strobes stay quiet for the whole reset cycle
    if (reset) begin
      dp.clear_board          = 1'b0;
      dp.validate_enable      = 1'b0;
      dp.find_row_enable      = 1'b0;
      dp.drop_token           = 1'b0;
      dp.switch_player_enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_connect_four_controller.sv
// Bench for connect_four_controller: directed scenarios plus random
// button traffic checked against a per-move timeline model.
module tb_connect_four_controller;

  localparam int NC   = 8;
  localparam int MAXC = 4096;
  localparam int BIG  = 32'h7fff_ffff;
  localparam logic [4:0] CLR = 5'b10000;
  localparam logic [4:0] VAL = 5'b01000;
  localparam logic [4:0] FND = 5'b00100;
  localparam logic [4:0] DRP = 5'b00010;
  localparam logic [4:0] SWS = 5'b00001;
`ifdef CF_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_drop = 1'b0;
  logic       btn_restart = 1'b0;
  logic [2:0] cursor_col;
  logic       game_over;
  logic [1:0] winner;
  logic [2:0] state_dbg;

  connect_four_controller_if dp_if ();

  connect_four_controller #(.NUM_COLS(NC)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_drop    (btn_drop),
    .btn_restart (btn_restart),
    .dp          (dp_if),
    .cursor_col  (cursor_col),
    .game_over   (game_over),
    .winner      (winner),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int t = 0;

  // timeline model: expected strobe per cycle index
  logic [4:0] e_strb [MAXC];
  logic [4:0] e_now = 5'b0;
  int  m_cur = 0;
  int  m_win = 0;
  bit  m_over = 1'b0;
  int  over_at = -1;
  int  over_val = 0;
  int  idle_from = BIG;
  int  clear_cycle = -1;
  bit  chk_en = 1'b0;
  bit  p_rst = 1'b1;
  bit  p_l, p_r, p_d, p_rs;
  bit  p_col, p_wf, p_bf;
  int  p_pl;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               nm, t, act, exp);
    end
  endtask

  task automatic abandon();
    for (int k = t; k < t + 8; k++) e_strb[k] = 5'b0;
    e_strb[t]   = CLR;
    clear_cycle = t;
    m_cur       = 0;
    m_win       = 0;
    m_over      = 1'b0;
    over_at     = -1;
    idle_from   = t + 1;
  endtask

  // apply the inputs of cycle t-1 to get the expectations of cycle t
  task automatic model_step();
    int n;
    n = t - 1;
    if (p_rst) begin
      abandon();
    end else if (p_rs && n != clear_cycle) begin
      abandon();
    end else if (n >= idle_from && !m_over) begin
      if (p_d) begin
        e_strb[n+1] = VAL;
        if (p_col) begin
          idle_from = n + 3;
        end else begin
          e_strb[n+3] = FND;
          e_strb[n+4] = DRP;
          if (p_wf || p_bf) begin
            over_at   = n + 5;
            over_val  = p_wf ? p_pl : 3;
            idle_from = BIG;
          end else begin
            e_strb[n+5] = SWS;
            idle_from   = n + 6;
          end
        end
      end else if (p_l && !p_r) begin
        if (m_cur == 0) m_cur = WRAP ? NC - 1 : 0;
        else m_cur = m_cur - 1;
      end else if (p_r && !p_l) begin
        if (m_cur == NC - 1) m_cur = WRAP ? 0 : NC - 1;
        else m_cur = m_cur + 1;
      end
    end
    if (t == over_at) begin
      m_over = 1'b1;
      m_win  = over_val;
    end
  endtask

  task automatic cyc(bit l, bit r, bit d, bit rs, bit rst, bit rnd);
    @(posedge clk);
    #1;
    t++;
    model_step();
    if (rnd && t >= idle_from && !m_over) begin
      dp_if.column_full    = ($urandom_range(0, 3) == 0);
      dp_if.win_found      = ($urandom_range(0, 4) == 0);
      dp_if.board_full     = ($urandom_range(0, 5) == 0);
      dp_if.current_player = 2'($urandom_range(1, 2));
    end
    btn_left    = l;
    btn_right   = r;
    btn_drop    = d;
    btn_restart = rs;
    reset       = rst;
    p_l = l; p_r = r; p_d = d; p_rs = rs; p_rst = rst;
    p_col = dp_if.column_full;
    p_wf  = dp_if.win_found;
    p_bf  = dp_if.board_full;
    p_pl  = int'(dp_if.current_player);
    e_now  = rst ? 5'b0 : e_strb[t];
    chk_en = 1'b1;
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_fb(bit col, bit wf, bit bf, int pl);
    dp_if.column_full    = col;
    dp_if.win_found      = wf;
    dp_if.board_full     = bf;
    dp_if.current_player = 2'(pl);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("strobes", {dp_if.clear_board, dp_if.validate_enable,
                      dp_if.find_row_enable, dp_if.drop_token,
                      dp_if.switch_player_enable}, e_now);
      chk("cursor_col", cursor_col, m_cur);
      chk("game_over", game_over, m_over);
      chk("winner", winner, m_win);
    end
  end

  initial begin
    for (int k = 0; k < MAXC; k++) e_strb[k] = 5'b0;
    set_fb(0, 0, 0, 1);

    cyc(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("lit_rst_clear", dp_if.clear_board, 0);
    chk("lit_rst_over", game_over, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_post_rst_clear", dp_if.clear_board, 1);
    chk("lit_post_rst_winner", winner, 0);

    // cursor movement and both-button cancel
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_right3", cursor_col, 3);
    cyc(1, 1, 0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_both", cursor_col, 3);

    // left edge
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_left_edge", cursor_col, WRAP ? 7 : 0);
    if (WRAP) cyc(0, 1, 0, 0, 0, 0);

    // full column
    set_fb(1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_full_val", dp_if.validate_enable, 1);
    idle(1);
    @(negedge clk);
    chk("lit_full_find", dp_if.find_row_enable, 0);
    cyc(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("lit_full_drop", dp_if.drop_token, 0);
    idle(1);
    @(negedge clk);
    chk("lit_full_wait", cursor_col, 1);

    // ordinary move
    set_fb(0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    idle(4);
    @(negedge clk);
    chk("lit_move_drop", dp_if.drop_token, 1);
    idle(1);
    @(negedge clk);
    chk("lit_move_switch", dp_if.switch_player_enable, 1);
    idle(1);

    // win on a full board
    set_fb(0, 1, 1, 2);
    cyc(0, 0, 1, 0, 0, 0);
    idle(5);
    @(negedge clk);
    chk("lit_win_over", game_over, 1);
    chk("lit_win_winner", winner, 2);
    chk("lit_win_switch", dp_if.switch_player_enable, 0);
    cyc(0, 1, 1, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_win_frozen", cursor_col, 1);
    cyc(0, 0, 0, 1, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_restart_clear", dp_if.clear_board, 1);
    chk("lit_restart_winner", winner, 0);
    chk("lit_restart_cursor", cursor_col, 0);

    // draw then restart
    set_fb(0, 0, 1, 1);
    cyc(0, 0, 1, 0, 0, 0);
    idle(5);
    @(negedge clk);
    chk("lit_draw_winner", winner, 3);
    cyc(0, 0, 0, 1, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_draw_clear", dp_if.clear_board, 1);
    chk("lit_draw_cleared", winner, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(1);
    @(negedge clk);
    chk("lit_draw_wait", cursor_col, 1);

    // restart during FIND
    set_fb(0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("lit_abort_find", dp_if.find_row_enable, 1);
    idle(1);
    @(negedge clk);
    chk("lit_abort_clear", dp_if.clear_board, 1);
    chk("lit_abort_drop", dp_if.drop_token, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      cyc($urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 29) == 0,
          $urandom_range(0, 199) == 0,
          1);
    end
    idle(8);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/connect_four_controller.md
CONNECT_FOUR_CONTROLLER -- requirements
Module: connect_four_controller

Interface
REQ-001 SHALL have parameter NUM_COLS, default 8, number of board columns; legal range 2..8.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port btn_left, input, 1, one-cycle debounced pulse: move cursor left.
REQ-005 SHALL have port btn_right, input, 1, one-cycle debounced pulse: move cursor right.
REQ-006 SHALL have port btn_drop, input, 1, one-cycle debounced pulse: drop a token in the cursor column.
REQ-007 SHALL have port btn_restart, input, 1, one-cycle debounced pulse: start a new game.
REQ-008 SHALL have inputs column_full, win_found and board_full, 1 bit each, datapath feedback.
REQ-009 SHALL have port current_player, input, 2, active player from the datapath (01 or 10).
REQ-010 SHALL have outputs clear_board, validate_enable, find_row_enable, drop_token and switch_player_enable, 1 bit each, one-cycle strobes to the datapath.
REQ-011 SHALL have port cursor_col, output, 3, active column.
REQ-012 SHALL have port game_over, output, 1, high in WIN or DRAW state.
REQ-013 SHALL have port winner, output, 2: 00 none, 01 or 10 winning player, 11 draw.
REQ-014 SHALL have port state_dbg, output, 3, encoded FSM state for display and debug.

Function
REQ-015 SHALL implement the states CLEAR, WAIT, VALIDATE, CHECK, FIND, DROP, SWITCH, WIN and DRAW.
REQ-016 SHALL drive all strobes from registered state decode only, with exactly one strobe high per cycle at most.
REQ-017 SHALL, in CLEAR, assert clear_board for one cycle, zero winner, then go to WAIT.
REQ-018 SHALL, in WAIT, give btn_drop priority: go to VALIDATE and leave the cursor unchanged even if left/right pulse the same cycle.
REQ-019 SHALL, in WAIT without drop, decrement cursor_col on btn_left alone and increment it on btn_right alone; left and right together are ignored.
REQ-020 SHALL update the cursor on the edge after the pulse.
REQ-021 SHALL, at the cursor edges, apply the REQ-035 rule: the cursor saturates at 0 and NUM_COLS-1 unless the wrap feature is compiled in.
REQ-022 SHALL, in VALIDATE, assert validate_enable for one cycle, then go to CHECK.
REQ-023 SHALL, in CHECK, sample column_full: if 1, return to WAIT with no other strobe; otherwise go to FIND.
REQ-024 SHALL, in FIND, assert find_row_enable for one cycle, then go to DROP.
REQ-025 SHALL, in DROP, assert drop_token for one cycle and sample win_found and board_full in that same cycle.
REQ-026 SHALL, on a DROP-cycle win, go to WIN and latch winner <= current_player.
REQ-027 SHALL, on a DROP cycle with no win and board_full, go to DRAW with winner <= 11.
REQ-028 SHALL, on a DROP cycle with neither win nor board_full, go to SWITCH; a simultaneous win and full board is a WIN.
REQ-029 SHALL, in SWITCH, assert switch_player_enable for one cycle, then go to WAIT.
REQ-030 SHALL, in WIN and DRAW, ignore left, right and drop, hold winner, and assert game_over.
REQ-031 SHALL treat btn_restart in any state except CLEAR as highest priority: next state CLEAR, any in-flight move abandoned, no further strobe for that move, cursor reset to 0.
REQ-032 SHALL complete a drop press in WAIT at cycle N as validate_enable at N+1, find_row_enable at N+3, drop_token at N+4, switch_player_enable at N+5, WAIT at N+6.

Reset
REQ-033 SHALL, while reset is high, load state CLEAR, cursor_col 0, winner 00 and game_over 0, with all strobes low that cycle.
REQ-034 SHALL, on the first cycle after reset deasserts, assert clear_board (CLEAR state); reset mid-move SHALL abandon the move with no further strobes.

Configuration
REQ-035 SHALL support macro CF_CURSOR_WRAP_EN: when defined, left at 0 goes to NUM_COLS-1 and right at NUM_COLS-1 goes to 0; when undefined, the cursor saturates at both ends.

Verification
REQ-036 SHALL cover movement: reset, then btn_right x3 -> cursor_col 3; then btn_left and btn_right in the same cycle -> cursor_col stays 3.
REQ-037 SHALL cover the edge: btn_left at cursor_col 0 -> cursor 0 without CF_CURSOR_WRAP_EN, cursor 7 with it (NUM_COLS=8).
REQ-038 SHALL cover a full column: btn_drop with column_full=1 in CHECK -> validate_enable one cycle, no find_row_enable or drop_token, back in WAIT at N+3.
REQ-039 SHALL cover a win: btn_drop with win_found=1 in the DROP cycle and current_player=10 -> WIN, winner=10, game_over=1, no switch_player_enable.
REQ-040 SHALL cover a draw: board_full=1 and win_found=0 at DROP -> DRAW, winner=11; then btn_restart -> clear_board one cycle, winner=00, cursor 0, WAIT.
REQ-041 SHALL cover abort: btn_restart during FIND -> next cycle CLEAR, drop_token never asserted.
